// File: rtl/fib_seq_ctrl.sv
// Sequencer that fills r[0..n-1] of a shared register file with a Fibonacci-style
// recurrence using an external ALU, with start/busy/done handshake and overflow flag.
module fib_seq_ctrl #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter logic [2:0] ALU_ADD = 3'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic [DW-1:0] init_a,
  input  logic [DW-1:0] init_b,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [AW-1:0] raddr1,
  output logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_y,
  output logic          wena,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT0 = 3'd1,
    ST_INIT1 = 3'd2,
    ST_READ  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [AW:0] N_MIN = (AW+1)'(2);
  localparam logic [AW:0] N_MAX = {1'b1, {AW{1'b0}}};

  function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
    logic [AW:0] r;
    if (c < N_MIN) begin
      r = N_MIN;
    end else if (c > N_MAX) begin
      r = N_MAX;
    end else begin
      r = c;
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [AW:0]   idx_r, idx_s, n_r, n_s;
  logic [DW-1:0] seed_a_r, seed_a_s, seed_b_r, seed_b_s;
  logic [DW-1:0] op_a_r, op_a_s, op_b_r, op_b_s, res_r, res_s;
  logic          ovf_r, ovf_s;
  logic          busy_r, busy_s, done_r, done_s, wena_r, wena_s;
  logic [AW-1:0] waddr_r, waddr_s, raddr1_r, raddr1_s, raddr2_r, raddr2_s;
  logic [DW-1:0] wdata_r, wdata_s;

  // Next-state and datapath register update
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    n_s      = n_r;
    seed_a_s = seed_a_r;
    seed_b_s = seed_b_r;
    op_a_s   = op_a_r;
    op_b_s   = op_b_r;
    res_s    = res_r;
    ovf_s    = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          seed_a_s = init_a;
          seed_b_s = init_b;
          n_s      = clamp_count(count);
          ovf_s    = 1'b0;
          idx_s    = N_MIN;
          state_s  = ST_INIT0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_INIT0: state_s = ST_INIT1;
      ST_INIT1: begin
        if (n_r == N_MIN) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_READ: begin
        op_a_s  = rdata1;
        op_b_s  = rdata2;
        state_s = ST_EXEC;
      end
      ST_EXEC: begin
        res_s = alu_y;
        // An unsigned add wrapped exactly when the sum is below an operand
        if (alu_y < op_a_r) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        idx_s = idx_r + (AW+1)'(1);
        if (idx_r == n_r - (AW+1)'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, so every output leaves a flop
  always_comb begin
    busy_s   = 1'b0;
    done_s   = 1'b0;
    wena_s   = 1'b0;
    waddr_s  = '0;
    wdata_s  = '0;
    raddr1_s = raddr1_r;
    raddr2_s = raddr2_r;
    case (state_s)
      ST_INIT0: begin
        busy_s  = 1'b1;
        wena_s  = 1'b1;
        waddr_s = AW'(0);
        wdata_s = seed_a_s;
      end
      ST_INIT1: begin
        busy_s  = 1'b1;
        wena_s  = 1'b1;
        waddr_s = AW'(1);
        wdata_s = seed_b_s;
      end
      ST_READ: begin
        busy_s   = 1'b1;
        raddr1_s = idx_s[AW-1:0] - AW'(2);
        raddr2_s = idx_s[AW-1:0] - AW'(1);
      end
      ST_EXEC: busy_s = 1'b1;
      ST_WRITE: begin
        busy_s  = 1'b1;
        wena_s  = 1'b1;
        waddr_s = idx_s[AW-1:0];
        wdata_s = res_s;
      end
      ST_DONE: done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      n_r      <= '0;
      seed_a_r <= '0;
      seed_b_r <= '0;
      op_a_r   <= '0;
      op_b_r   <= '0;
      res_r    <= '0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      wena_r   <= 1'b0;
      waddr_r  <= '0;
      wdata_r  <= '0;
      raddr1_r <= '0;
      raddr2_r <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      n_r      <= n_s;
      seed_a_r <= seed_a_s;
      seed_b_r <= seed_b_s;
      op_a_r   <= op_a_s;
      op_b_r   <= op_b_s;
      res_r    <= res_s;
      ovf_r    <= ovf_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      wena_r   <= wena_s;
      waddr_r  <= waddr_s;
      wdata_r  <= wdata_s;
      raddr1_r <= raddr1_s;
      raddr2_r <= raddr2_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign ovf    = ovf_r;
  assign wena   = wena_r;
  assign waddr  = waddr_r;
  assign wdata  = wdata_r;
  assign raddr1 = raddr1_r;
  assign raddr2 = raddr2_r;
  assign alu_a  = op_a_r;
  assign alu_b  = op_b_r;
  assign alu_op = ALU_ADD;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: behavioural register file and ALU,
// expected writes queued per run and compared as the sequencer writes them.
module tb_fib_seq_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW:0]   count;
  logic [DW-1:0] init_a, init_b;
  logic          busy, done, ovf, wena;
  logic [AW-1:0] raddr1, raddr2, waddr;
  logic [DW-1:0] rdata1, rdata2, alu_a, alu_b, alu_y, wdata;
  logic [2:0]    alu_op;

  logic [DW-1:0] rf [0:(1<<AW)-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ovf;
  } wr_t;
  wr_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  fib_seq_ctrl #(.AW(AW), .DW(DW), .ALU_ADD(3'd1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .init_a(init_a), .init_b(init_b), .busy(busy), .done(done), .ovf(ovf),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .wena(wena), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];
  assign alu_y  = (alu_op == 3'd1) ? (alu_a + alu_b) : 32'h0;

  always @(posedge clk) begin
    if (wena) rf[waddr] <= wdata;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_ovf"}, 64'(ovf), 64'd0);
    check_eq({tag, "_wena"}, 64'(wena), 64'd0);
    check_eq({tag, "_waddr"}, 64'(waddr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(wdata), 64'd0);
    check_eq({tag, "_raddr"}, {32'(raddr1), 32'(raddr2)}, 64'd0);
    check_eq({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    check_eq({tag, "_alu_op"}, 64'(alu_op), 64'd1);
  endtask

  // inj_kind: 0 none, 1 start pulse (count=4) at cycle inj_cyc, 2 reset at cycle inj_cyc
  task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input int cnt,
                     input int inj_cyc, input int inj_kind);
    int n;
    int c;
    bit finished;
    logic [DW:0] s;
    logic [DW-1:0] t0, t1;
    logic ov;
    wr_t w;
    n = (cnt < 2) ? 2 : ((cnt > (1 << AW)) ? (1 << AW) : cnt);
    sb.delete();
    sb.push_back('{AW'(0), a, 1'b0});
    sb.push_back('{AW'(1), b, 1'b0});
    t0 = a; t1 = b; ov = 1'b0;
    for (int k = 2; k < n; k++) begin
      s = {1'b0, t0} + {1'b0, t1};
      if (s[DW]) ov = 1'b1;
      sb.push_back('{AW'(k), s[DW-1:0], ov});
      t0 = t1;
      t1 = s[DW-1:0];
    end
    @(negedge clk);
    init_a = a; init_b = b; count = cnt[AW:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finished = 1'b0;
    for (c = 1; c <= 400; c++) begin
      if (inj_kind == 1 && c == inj_cyc) begin
        start = 1'b1; count = 7'd4;
      end else if (inj_kind == 1 && c == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (inj_kind == 2 && c == inj_cyc) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        finished = 1'b1;
        break;
      end
      check_eq($sformatf("busy_c%0d", c), 64'(busy), 64'(c <= 3*n-4));
      if (wena) begin
        if (sb.size() == 0) begin
          check_eq("extra_write", 64'(waddr), 64'hFFFF);
        end else begin
          w = sb.pop_front();
          check_eq($sformatf("waddr_c%0d", c), 64'(waddr), 64'(w.addr));
          check_eq($sformatf("wdata_r%0d", w.addr), 64'(wdata), 64'(w.data));
          check_eq($sformatf("ovf_r%0d", w.addr), 64'(ovf), 64'(w.ovf));
        end
      end
      if (done) begin
        check_eq("done_cycle", 64'(c), 64'(3*n-3));
        check_eq("writes_left", 64'(sb.size()), 64'd0);
        check_eq("ovf_at_done", 64'(ovf), 64'(ov));
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!finished) check_eq("done_timeout", 64'd0, 64'd1);
    if (inj_kind != 2) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check_eq("idle_quiet", {61'd0, busy, done, wena}, 64'd0);
        check_eq("idle_ovf", 64'(ovf), 64'(ov));
      end
    end
  endtask

  initial begin
    logic [DW-1:0] old_r3;
    rst_n = 1'b0; start = 1'b0; count = '0; init_a = '0; init_b = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(32'd0, 32'd1, 6, 0, 0);
    check_eq("basic_r5", 64'(rf[5]), 64'd5);
    check_eq("basic_r4", 64'(rf[4]), 64'd3);

    run(32'd7, 32'd9, 0, 0, 0);
    check_eq("clamp_low_r0", 64'(rf[0]), 64'd7);
    check_eq("clamp_low_r1", 64'(rf[1]), 64'd9);

    run(32'h8000_0000, 32'h8000_0000, 3, 0, 0);
    check_eq("ovf_r2", 64'(rf[2]), 64'd0);
    check_eq("ovf_sticky_idle", 64'(ovf), 64'd1);

    run(32'd0, 32'd1, 127, 0, 0);
    check_eq("full_r47", 64'(rf[47]), 64'hB119_24E1);
    check_eq("full_r48", 64'(rf[48]), 64'h1E8D_0A40);
    check_eq("full_r63", 64'(rf[63]), 64'(32'(64'd6557470319842 & 64'hFFFF_FFFF)));

    run(32'd2, 32'd3, 5, 5, 1);
    check_eq("ignored_r4", 64'(rf[4]), 64'd13);

    old_r3 = rf[3];
    run(32'd5, 32'd7, 6, 7, 2);
    repeat (2) @(negedge clk);
    check_eq("rst_r3_kept", 64'(rf[3]), 64'(old_r3));
    check_eq("rst_r2_kept", 64'(rf[2]), 64'd12);

    run(32'd5, 32'd7, 6, 0, 0);
    check_eq("after_rst_r5", 64'(rf[5]), 64'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencer that drives the shared register file and ALU to fill a block of registers with a Fibonacci-style recurrence, r[i] = r[i-2] + r[i-1]. On a start request it writes two seed values into r[0] and r[1], then produces each further term with a read, execute, write-back cycle. It replaces free-running read/write address generation in the register-file/ALU datapath with an explicit start/busy/done handshake and overflow reporting.

## Interface
- AW, 6, register-file address width; the block uses registers 0..2^AW-1
- DW, 32, data width
- ALU_ADD, 3'd1, ALU opcode for add, driven on alu_op

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- count  in  AW+1  number of terms to produce; captured at start
- init_a  in  DW  seed for r[0]; captured at start
- init_b  in  DW  seed for r[1]; captured at start
- busy  out  1  high from INIT0 through the last WRITE
- done  out  1  one-cycle pulse in DONE
- ovf  out  1  sticky unsigned-overflow flag for the current run
- raddr1  out  AW  register-file read port 1 address
- raddr2  out  AW  register-file read port 2 address
- rdata1  in  DW  read port 1 data; combinational from raddr1
- rdata2  in  DW  read port 2 data; combinational from raddr2
- alu_a  out  DW  ALU operand A
- alu_b  out  DW  ALU operand B
- alu_op  out  3  ALU opcode; constant ALU_ADD
- alu_y  in  DW  ALU result; combinational
- wena  out  1  register-file write enable
- waddr  out  AW  write address
- wdata  out  DW  write data

## Operation
- States: IDLE, INIT0, INIT1, READ, EXEC, WRITE, DONE.
- All outputs are decoded from state and internal registers only. There is no combinational path from any input to any output.
- **IDLE**
  - When start=1: capture init_a, init_b and n = clamp(count).
  - clamp: values below 2 become 2; values above 2^AW become 2^AW.
  - Clear ovf, set idx=2, go to INIT0.
  - start is ignored in every other state.
- **INIT0**: wena=1, waddr=0, wdata=seed_a. Go to INIT1.
- **INIT1**: wena=1, waddr=1, wdata=seed_b. Go to DONE if n==2, otherwise go to READ.
- **READ**: raddr1=idx-2, raddr2=idx-1. Latch op_a<=rdata1, op_b<=rdata2. Go to EXEC.
- **EXEC**
  - Drive alu_a=op_a, alu_b=op_b.
  - Latch res<=alu_y.
  - If alu_y < op_a (unsigned wrap), set ovf<=1. Go to WRITE.
- **WRITE**
  - wena=1, waddr=idx[AW-1:0], wdata=res. idx<=idx+1.
  - Go to DONE if idx==n-1, otherwise go to READ.
  - The wrapped sum is still written when ovf is set.
- **DONE**: done=1, busy=0. Go to IDLE unconditionally. A new start is accepted in the following IDLE cycle.
- Outside the active states:
  - wena=0 outside INIT0, INIT1 and WRITE.
  - raddr1/raddr2 hold their last values outside READ.
  - alu_a/alu_b hold op_a/op_b.
- ovf keeps its value through DONE and IDLE until the next accepted start.

## Timing
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, ovf=0, wena=0, waddr=0, wdata=0, raddr1=0, raddr2=0, alu_a=0, alu_b=0, alu_op=ALU_ADD.
- Reset mid-run:
  - wena drops without waiting for a clock edge; no further writes occur.
  - Registers already written keep their contents; this block does not clear the register file.
- Cycle numbering: start is sampled high at edge E0.
  - INIT0 occupies cycle 1 (the cycle after E0); INIT1 occupies cycle 2.
  - Term k (k≥2) occupies cycles 3(k-2)+3, +4, +5 for READ, EXEC, WRITE respectively.
  - DONE occupies cycle 3(n-2)+3.
  - Total from start to done: 3n-3 cycles.
- Write-to-read ordering: term k's READ follows the write of r[k-1] in the preceding WRITE cycle. The register file must therefore return written data on the next cycle. Same-cycle write/read bypass is not required.
- At most one write per cycle; waddr is strictly increasing within a run.

## Test plan
- **Basic run**: init_a=0, init_b=1, count=6 → r0..r5 = 0,1,1,2,3,5; done pulses in cycle 15; ovf=0; busy high in cycles 1..14.
- **Clamp low**: count=0, seeds 7 and 9 → exactly two writes (r0=7, r1=9); done in cycle 3.
- **Clamp high, full register file**: count=127, seeds 0 and 1 → 64 writes (r0..r63).
  - r47=0xB11924E1 with ovf still 0 after term 47.
  - ovf=1 from term 48 onward (r48=0x1E8D0A40, the wrapped value).
- **Start ignored while busy**: assert start with count=4 during the WRITE of term 2 of a count=5 run → the run completes unchanged; no second run starts.
- **Overflow**: init_a=init_b=0x80000000, count=3 → r2=0x00000000, ovf=1; ovf stays 1 in IDLE and clears on the next accepted start.
- **Reset mid-run**: drop rst_n during the EXEC of term 3 → wena=0 immediately with no write to r3; after release, a fresh start produces correct results.
